// File: rtl/sap2_pkg.sv
// ----------------------------------------------------------------------------
// sap2_pkg
// Constants shared by the SAP-2 fetch stage and the controller.
//   - Data and address widths.
//   - Bit positions of the fetch strobes in the 30-bit control word.
//   - NOP/HLT opcodes and the instruction-register reset value.
//   - A struct holding the decoded fetch strobes.
// ----------------------------------------------------------------------------
package sap2_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int CON_W  = 30;

    // Fetch strobe positions inside the control word (shared with ctrl).
    localparam int CON_CP = 29;  // increment program counter
    localparam int CON_EP = 28;  // drive program counter onto W
    localparam int CON_LP = 27;  // load program counter from W
    localparam int CON_LM = 26;  // load memory address register from W
    localparam int CON_LI = 25;  // load instruction register from W
    localparam int CON_EI = 24;  // drive instruction operand nibble onto W

    localparam logic [3:0] OP_NOP = 4'hF;
    localparam logic [3:0] OP_HLT = 4'hE;

    // IR comes out of reset holding a NOP so the controller idles.
    localparam logic [DATA_W-1:0] IR_RESET = {OP_NOP, 4'h0};

    typedef struct packed {
        logic cp;
        logic ep;
        logic lp;
        logic lm;
        logic li;
        logic ei;
    } fetch_strobes_t;

endpackage

// File: rtl/sap2_fetch_if.sv
// ----------------------------------------------------------------------------
// sap2_fetch_if
// Bus-side signals of the fetch stage.
//   con    control word from ctrl
//   w_in   resolved W bus value
//   w_out  value the fetch stage drives onto W
//   w_oe   fetch stage is driving W
//   mar    RAM address
//   pc     program counter
//   i      instruction register
//   err    sticky bus-contention flag
// Modports: slave = fetch stage, master = surrounding CPU / bench.
// W is a plain resolved bus: there is no handshake; a value placed on
// w_in is sampled by every loading register on the same rising edge.
// ----------------------------------------------------------------------------
interface sap2_fetch_if;
    import sap2_pkg::*;

    logic [CON_W-1:0]  con;
    logic [DATA_W-1:0] w_in;
    logic [DATA_W-1:0] w_out;
    logic              w_oe;
    logic [ADDR_W-1:0] mar;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] i;
    logic              err;

    modport slave (
        input  con, w_in,
        output w_out, w_oe, mar, pc, i, err
    );

    modport master (
        output con, w_in,
        input  w_out, w_oe, mar, pc, i, err
    );

endinterface

// File: rtl/sap2_pc.sv
// ----------------------------------------------------------------------------
// sap2_pc
// 4-bit loadable program counter, wraps 15 -> 0, asynchronous clear.
// Ports:
//   clk         clock, rising edge
//   clr         asynchronous active-high clear
//   inc_i       count up by one
//   load_i      load load_val_i (takes priority over inc_i)
//   load_val_i  value to load
//   pc_o        current count
// ----------------------------------------------------------------------------
module sap2_pc
    import sap2_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;  // natural 4-bit wrap
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/sap2_fetch.sv
// ----------------------------------------------------------------------------
// sap2_fetch
// PC / MAR / IR stage of the SAP-2 CPU. Acts on the CP, EP, LP, LM, LI, EI
// strobes of the control word and drives the instruction byte to ctrl.
// Ports:
//   clk       clock, rising edge
//   clr       asynchronous active-high reset
//   bus       sap2_fetch_if.slave (con, w_in, w_out, w_oe, mar, pc, i, err)
//   brk_en    breakpoint enable
//   brk_addr  breakpoint address
//   brk       one-cycle breakpoint hit pulse
// Configuration macro: FETCH_BRK_EN adds the breakpoint comparator; when it
// is undefined brk is tied low and brk_en/brk_addr are ignored.
// ----------------------------------------------------------------------------
module sap2_fetch
    import sap2_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    sap2_fetch_if.slave       bus,
    input  logic              brk_en,
    input  logic [ADDR_W-1:0] brk_addr,
    output logic              brk
);

    fetch_strobes_t    s;
    logic [ADDR_W-1:0] pc_val;

    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              err_q, err_d;

    assign s.cp = bus.con[CON_CP];
    assign s.ep = bus.con[CON_EP];
    assign s.lp = bus.con[CON_LP];
    assign s.lm = bus.con[CON_LM];
    assign s.li = bus.con[CON_LI];
    assign s.ei = bus.con[CON_EI];

    sap2_pc u_pc (
        .clk        (clk),
        .clr        (clr),
        .inc_i      (s.cp),
        .load_i     (s.lp),
        .load_val_i (bus.w_in[ADDR_W-1:0]),
        .pc_o       (pc_val)
    );

    // W bus driver: EP has priority over EI; only the operand nibble of IR
    // is ever placed on the bus.
    always_comb begin
        bus.w_out = '0;
        bus.w_oe  = 1'b0;
        if (s.ep) begin
            bus.w_out = {{(DATA_W-ADDR_W){1'b0}}, pc_val};
            bus.w_oe  = 1'b1;
        end else if (s.ei) begin
            bus.w_out = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
            bus.w_oe  = 1'b1;
        end
    end

    always_comb begin
        mar_d = mar_q;
        ir_d  = ir_q;
        if (s.lm) mar_d = bus.w_in[ADDR_W-1:0];
        if (s.li) ir_d  = bus.w_in;
        // Two sources enabled at once is a controller bug; remember it.
        err_d = err_q | (s.ep & s.ei);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mar_q <= '0;
            ir_q  <= IR_RESET;
            err_q <= 1'b0;
        end else begin
            mar_q <= mar_d;
            ir_q  <= ir_d;
            err_q <= err_d;
        end
    end

    assign bus.mar = mar_q;
    assign bus.pc  = pc_val;
    assign bus.i   = ir_q;
    assign bus.err = err_q;

`ifdef FETCH_BRK_EN
    // Breakpoint fires on the T1 edge of a fetch (EP+LM) from brk_addr and
    // is visible for exactly the following cycle.
    logic brk_q, brk_d;

    always_comb begin
        brk_d = s.ep & s.lm & brk_en & (pc_val == brk_addr);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            brk_q <= 1'b0;
        end else begin
            brk_q <= brk_d;
        end
    end

    assign brk = brk_q;

    // Only the fetch strobes of the control word are used here.
    logic unused_con;
    assign unused_con = ^bus.con;
`else
    assign brk = 1'b0;

    logic unused_in;
    assign unused_in = ^{bus.con, brk_en, brk_addr};
`endif

endmodule

// File: tb/tb_sap2_fetch.sv
// ----------------------------------------------------------------------------
// tb_sap2_fetch
// Directed bench for sap2_fetch: reset, fetch sequence, PC wrap and load
// priority, jump, bus contention, mid-cycle reset, breakpoint.
// ----------------------------------------------------------------------------
module tb_sap2_fetch;
    import sap2_pkg::*;

    localparam logic [CON_W-1:0] C_CP = CON_W'(1) << CON_CP;
    localparam logic [CON_W-1:0] C_EP = CON_W'(1) << CON_EP;
    localparam logic [CON_W-1:0] C_LP = CON_W'(1) << CON_LP;
    localparam logic [CON_W-1:0] C_LM = CON_W'(1) << CON_LM;
    localparam logic [CON_W-1:0] C_LI = CON_W'(1) << CON_LI;
    localparam logic [CON_W-1:0] C_EI = CON_W'(1) << CON_EI;

    logic       clk;
    logic       clr;
    logic       brk_en;
    logic [3:0] brk_addr;
    logic       brk;
    logic       brk_on;

    int n_pass;
    int n_total;

    sap2_fetch_if bus ();

    sap2_fetch dut (
        .clk      (clk),
        .clr      (clr),
        .bus      (bus),
        .brk_en   (brk_en),
        .brk_addr (brk_addr),
        .brk      (brk)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic drive(input logic [CON_W-1:0] c, input logic [7:0] w);
        bus.con  = c;
        bus.w_in = w;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
`ifdef FETCH_BRK_EN
        brk_on   = 1'b1;
`else
        brk_on   = 1'b0;
`endif
        clr      = 1'b1;
        brk_en   = 1'b0;
        brk_addr = 4'h0;
        bus.con  = '0;
        bus.w_in = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_pc", 32'(bus.pc), 32'h0);
        check("rst_mar", 32'(bus.mar), 32'h0);
        check("rst_i", 32'(bus.i), 32'hF0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_brk", 32'(brk), 32'h0);
        check("rst_oe", 32'(bus.w_oe), 32'h0);
        clr = 1'b0;

        // Fetch of RAM word 0 = 8'h1A
        drive(C_EP | C_LM, 8'h00);
        check("t1_wout", 32'(bus.w_out), 32'h00);
        check("t1_oe", 32'(bus.w_oe), 32'h1);
        tick();
        check("t1_mar", 32'(bus.mar), 32'h0);
        check("t1_pc", 32'(bus.pc), 32'h0);
        drive(C_CP, 8'h00);
        check("t2_oe", 32'(bus.w_oe), 32'h0);
        tick();
        check("t2_pc", 32'(bus.pc), 32'h1);
        drive(C_LI, 8'h1A);
        check("t3_oe", 32'(bus.w_oe), 32'h0);
        tick();
        check("t3_i", 32'(bus.i), 32'h1A);
        check("t3_pc", 32'(bus.pc), 32'h1);

        // Wrap and LP-over-CP priority
        drive(C_LP, 8'h0F);
        tick();
        check("ld_pc15", 32'(bus.pc), 32'hF);
        drive(C_CP, 8'h00);
        tick();
        check("wrap_pc", 32'(bus.pc), 32'h0);
        drive(C_LP, 8'h03);
        tick();
        check("ld_pc3", 32'(bus.pc), 32'h3);
        drive(C_CP | C_LP, 8'h09);
        tick();
        check("lp_prio", 32'(bus.pc), 32'h9);

        // Jump through IR operand
        drive(C_LI, 8'h6C);
        tick();
        check("jmp_i", 32'(bus.i), 32'h6C);
        drive(C_EI | C_LP, 8'h0C);
        check("jmp_wout", 32'(bus.w_out), 32'h0C);
        check("jmp_oe", 32'(bus.w_oe), 32'h1);
        tick();
        check("jmp_pc", 32'(bus.pc), 32'hC);
        drive(C_LP, 8'hF5);
        tick();
        check("ld_hi_ign", 32'(bus.pc), 32'h5);
        drive(C_LM, 8'hA9);
        tick();
        check("lm_mar", 32'(bus.mar), 32'h9);
        drive(C_LP | C_LM | C_LI, 8'h3B);
        tick();
        check("multi_pc", 32'(bus.pc), 32'hB);
        check("multi_mar", 32'(bus.mar), 32'hB);
        check("multi_i", 32'(bus.i), 32'h3B);

        // Contention
        drive(C_LP, 8'h02);
        tick();
        drive(C_LI, 8'h07);
        tick();
        check("pre_err", 32'(bus.err), 32'h0);
        drive(C_EP | C_EI, 8'h02);
        check("cont_wout", 32'(bus.w_out), 32'h02);
        check("cont_oe", 32'(bus.w_oe), 32'h1);
        tick();
        check("cont_err", 32'(bus.err), 32'h1);
        drive('0, 8'h00);
        check("idle_wout", 32'(bus.w_out), 32'h00);
        check("idle_oe", 32'(bus.w_oe), 32'h0);
        tick();
        check("err_hold1", 32'(bus.err), 32'h1);
        drive(C_EI, 8'h00);
        check("ei_wout", 32'(bus.w_out), 32'h07);
        tick();
        check("err_hold2", 32'(bus.err), 32'h1);

        // Mid-cycle reset pulse
        drive('0, 8'h00);
        #2;
        clr = 1'b1;
        #1;
        check("mid_pc", 32'(bus.pc), 32'h0);
        check("mid_mar", 32'(bus.mar), 32'h0);
        check("mid_i", 32'(bus.i), 32'hF0);
        check("mid_err", 32'(bus.err), 32'h0);
        drive(C_CP | C_LP | C_LM | C_LI, 8'h55);
        tick();
        check("clr_pc", 32'(bus.pc), 32'h0);
        check("clr_mar", 32'(bus.mar), 32'h0);
        check("clr_i", 32'(bus.i), 32'hF0);
        drive(C_EP, 8'h00);
        check("clr_ep_oe", 32'(bus.w_oe), 32'h1);
        drive(C_EP | C_EI, 8'h00);
        tick();
        check("clr_err", 32'(bus.err), 32'h0);
        clr = 1'b0;
        drive('0, 8'h00);
        tick();

        // Breakpoint at address 4, enabled
        brk_addr = 4'h4;
        brk_en   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(C_EP | C_LM, 8'(k));
            check("bp_wout", 32'(bus.w_out), 32'(k));
            tick();
            check("bp_mar", 32'(bus.mar), 32'(k));
            check("bp_hit", 32'(brk), 32'(brk_on && (k == 4)));
            drive(C_CP, 8'h00);
            tick();
            check("bp_pc", 32'(bus.pc), 32'(k + 1));
            check("bp_low", 32'(brk), 32'h0);
            drive(C_LI, 8'hF0);
            tick();
        end

        // Breakpoint disabled
        brk_en = 1'b0;
        drive(C_LP, 8'h00);
        tick();
        for (int k = 0; k < 6; k++) begin
            drive(C_EP | C_LM, 8'(k));
            tick();
            check("bp_off", 32'(brk), 32'h0);
            drive(C_CP, 8'h00);
            tick();
        end

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sap2_fetch.md
# sap2_fetch

Program-counter / memory-address / instruction-register stage of the SAP-2 mini CPU, directly upstream of `ctrl`. It holds the 4-bit program counter, the 4-bit memory address register and the 8-bit instruction register, acts on fetch strobes taken from `ctrl`'s 30-bit control word `con`, and drives the instruction byte `i` consumed by `ctrl`. It sits on the shared W bus alongside the accumulator, B/X registers and RAM.

## Interface
Parameters:
- none; bus and address widths are package constants (data 8, address 4).

Ports:
- clk  in  1  system clock; all state changes on rising edge
- clr  in  1  reset, asynchronous, active-high
- con  in  30  control word from `ctrl`; only the fetch strobes CP, EP, LP, LM, LI, EI are used
- w_in  in  8  resolved W bus value (RAM output or any register driving the bus)
- w_out  out  8  value this block drives onto W
- w_oe  out  1  this block is driving W
- mar  out  4  RAM address
- pc  out  4  current program counter
- i  out  8  instruction register, to `ctrl`
- err  out  1  sticky bus-contention flag
- brk_en  in  1  breakpoint enable (ignored unless FETCH_BRK_EN)
- brk_addr  in  4  breakpoint address (ignored unless FETCH_BRK_EN)
- brk  out  1  breakpoint hit pulse

## Operation
- CP: pc <= pc + 1, modulo 16 (15 -> 0, no flag).
- LP: pc <= w_in[3:0]. LP and CP together: LP wins, no increment.
- LM: mar <= w_in[3:0].
- LI: i <= w_in[7:0]; upper nibble is the opcode, lower nibble the operand address.
- EP: w_out = {4'h0, pc}, w_oe = 1.
- EI: w_out = {4'h0, i[3:0]}, w_oe = 1.
- EP and EI together: w_out = PC form (EP priority), err set to 1 on that edge and held until clr.
- Neither EP nor EI: w_out = 8'h00, w_oe = 0.
- LP, LM, LI may be active in any combination with each other and with EP/EI; each register samples the same w_in.
- Fetch sequence as issued by `ctrl`: T1 EP+LM, T2 CP, T3 LI (RAM on bus). JMP/JAN/JAZ/JIN/JIZ taken: EI+LP. JMS: EP drives return address to RAM, then EI+LP.

## Timing
- w_out, w_oe: combinational from con and registers, zero latency.
- pc, mar, i, err: registered, visible one clock after strobe edge.
- Reset values (async, immediate on clr rise, held while clr high): pc = 0, mar = 0, i = 8'hF0 (NOP, so `ctrl` idles), err = 0, brk = 0. w_out/w_oe follow con combinationally during reset.
- Strobes during clr high have no effect on registers.
- clr released mid-instruction: block resumes from reset values; no partial state survives.

## Configuration
- FETCH_BRK_EN defined: on a rising edge where EP and LM are both active, brk_en = 1 and pc == brk_addr, brk = 1 for the following cycle only; fetch continues unaffected (halting is `ctrl`'s job via external logic).
- FETCH_BRK_EN undefined: no comparator or brk register; brk tied 0; brk_en/brk_addr ports present but unused.

## Structure
- Shared package `sap2_pkg`: data/address width constants, control-word bit indices for CP, EP, LP, LM, LI, EI (shared with `ctrl`), NOP and HLT opcode constants, IR reset value.
- One natural sub-module: `sap2_pc`, the 4-bit loadable wrapping counter with async clear; MAR, IR and bus mux stay in the top.

## Test plan
- Reset: set state, pulse clr mid-cycle -> pc=0, mar=0, i=8'hF0, err=0 before next clk edge.
- Fetch: RAM word 0 = 8'h1A, EP+LM, CP, LI -> mar=0, pc=1, i=8'h1A, w_out=8'h00 during EP, w_oe high only in T1.
- Wrap/priority: pc=15, CP -> pc=0; pc=3, CP+LP with w_in=8'h09 -> pc=9.
- Jump: i=8'h6C, EI+LP -> w_out=8'h0C, pc=12; upper nibble ignored on load with w_in=8'hF5 -> pc=5.
- Contention: EP+EI, pc=2, i=8'h07 -> w_out=8'h02, err=1 next cycle, stays 1 until clr.
- Breakpoint (FETCH_BRK_EN): brk_addr=4, brk_en=1, run fetches 0..5 -> brk high exactly one cycle after the pc=4 fetch T1; brk_en=0 -> never high; macro off -> brk constant 0.
